// File: rtl/weight_loader.sv
// Byte-stream weight loader: assembles big-endian words and writes them one-hot into per-neuron RAMs.
// Optional trailing mod-256 checksum byte enabled by WEIGHT_LOADER_CHECKSUM_EN.
module weight_loader #(
  parameter int numNeurons   = 16,
  parameter int numWeights   = 16,
  parameter int addressWidth = 4,
  parameter int dataWidth    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [7:0]              byteIn,
  input  logic                    byteValid,
  output logic                    byteReady,
  output logic [numNeurons-1:0]   writeEn,
  output logic [addressWidth-1:0] addr,
  output logic [dataWidth-1:0]    dataOut,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int B  = dataWidth / 8;
  localparam int BW = (B > 1) ? $clog2(B) : 1;
  localparam int NW = (numNeurons > 1) ? $clog2(numNeurons) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ASM, S_WR, S_CHK, S_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [BW-1:0]           r_bcnt;
  logic [NW-1:0]           r_neuron;
  logic [addressWidth-1:0] r_addr;
  logic [dataWidth-1:0]    r_word;
  logic [dataWidth-1:0]    r_data;
  logic [dataWidth-1:0]    w_shift;
  logic                    w_xfer;
  logic                    w_last_byte;
  logic                    w_addr_end;
  logic                    w_last_word;

  assign w_xfer      = byteValid && byteReady;
  assign w_shift     = (r_word << 8) | dataWidth'(byteIn);
  assign w_last_byte = (r_bcnt == BW'(B - 1));
  assign w_addr_end  = (r_addr == addressWidth'(numWeights - 1));
  assign w_last_word = w_addr_end && (r_neuron == NW'(numNeurons - 1));
  assign addr        = r_addr;
  assign dataOut     = r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_next = S_ASM;
      S_ASM:  if (w_xfer && w_last_byte) w_next = S_WR;
      S_WR: begin
        if (!w_last_word) w_next = S_ASM;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        else              w_next = S_CHK;
`else
        else              w_next = S_DONE;
`endif
      end
      S_CHK:  if (w_xfer) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    byteReady = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    writeEn   = '0;
    unique case (r_state)
      S_ASM: begin
        byteReady = 1'b1;
        busy      = 1'b1;
      end
      S_WR: begin
        busy    = 1'b1;
        writeEn = numNeurons'(1) << r_neuron;
      end
      S_CHK: begin
        byteReady = 1'b1;
        busy      = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Counters hold after the last word so the final position stays visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcnt   <= '0;
      r_neuron <= '0;
      r_addr   <= '0;
      r_word   <= '0;
      r_data   <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_bcnt   <= '0;
        r_neuron <= '0;
        r_addr   <= '0;
      end
      if (r_state == S_ASM && w_xfer) begin
        r_word <= w_shift;
        if (w_last_byte) begin
          r_bcnt <= '0;
          r_data <= w_shift;
        end else begin
          r_bcnt <= r_bcnt + BW'(1);
        end
      end
      if (r_state == S_WR && !w_last_word) begin
        if (w_addr_end) begin
          r_addr   <= '0;
          r_neuron <= r_neuron + NW'(1);
        end else begin
          r_addr <= r_addr + addressWidth'(1);
        end
      end
    end
  end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic       r_error;

  assign error = r_error;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum   <= '0;
      r_error <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_sum   <= '0;
        r_error <= 1'b0;
      end
      if (r_state == S_ASM && w_xfer) r_sum <= r_sum + byteIn;
      if (r_state == S_CHK && w_xfer) r_error <= (byteIn != r_sum);
    end
  end
`else
  assign error = 1'b0;
`endif

endmodule
